// File: rtl/multi_port_queue_pkg.sv
// Shared defaults and width helpers for the multi-port queue.
// Used by the queue, its interface and anything that instantiates them.
package multi_port_queue_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_QUEUE_DEPTH = 64;
    localparam int DEFAULT_ENQ_WIDTH   = 2;
    localparam int DEFAULT_DEQ_WIDTH   = 2;

    // Bits needed to hold a count from 0 up to and including max_value.
    function automatic int count_width(input int max_value);
        return $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/multi_port_queue_if.sv
// Producer/consumer bundle of the multi-port queue.
// The master drives requests and data; the slave is the queue itself.
interface multi_port_queue_if
    import multi_port_queue_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH,
    parameter int ENQ_WIDTH   = DEFAULT_ENQ_WIDTH,
    parameter int DEQ_WIDTH   = DEFAULT_DEQ_WIDTH
);

    localparam int ENQ_CNT_W = count_width(ENQ_WIDTH);
    localparam int DEQ_CNT_W = count_width(DEQ_WIDTH);
    localparam int CNT_W     = count_width(QUEUE_DEPTH);

    logic                            flush_in;
    logic [ENQ_CNT_W-1:0]            enq_count_in;
    logic [ENQ_WIDTH*DATA_WIDTH-1:0] wdata_in;
    logic                            enq_ready_out;
    logic [DEQ_CNT_W-1:0]            deq_count_in;
    logic [DEQ_WIDTH*DATA_WIDTH-1:0] rdata_out;
    logic [DEQ_WIDTH-1:0]            rvalid_out;
    logic [CNT_W-1:0]                used_count_out;
    logic [CNT_W-1:0]                free_count_out;
    logic                            full_out;
    logic                            empty_out;

    modport master (
        output flush_in, enq_count_in, wdata_in, deq_count_in,
        input  enq_ready_out, rdata_out, rvalid_out, used_count_out,
               free_count_out, full_out, empty_out
    );

    modport slave (
        input  flush_in, enq_count_in, wdata_in, deq_count_in,
        output enq_ready_out, rdata_out, rvalid_out, used_count_out,
               free_count_out, full_out, empty_out
    );

endinterface

// File: rtl/multi_port_queue_ptr_ctr.sv
// Wrap pointer (index plus wrap bit) for the multi-port queue.
// Advances by a variable step each cycle; clear returns it to zero.
module queue_ptr_ctr #(
    parameter int PTR_W = 7,
    parameter int INC_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [INC_W-1:0] inc,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else begin
            ptr <= ptr + PTR_W'(inc);
        end
    end

endmodule

// File: rtl/multi_port_queue.sv
// Circular FIFO accepting up to ENQ_WIDTH and releasing up to DEQ_WIDTH
// entries per cycle, with synchronous flush and occupancy counters.
module multi_port_queue
    import multi_port_queue_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH,
    parameter int ENQ_WIDTH   = DEFAULT_ENQ_WIDTH,
    parameter int DEQ_WIDTH   = DEFAULT_DEQ_WIDTH
) (
    input logic               clk,
    input logic               rst,
    multi_port_queue_if.slave q
);

    localparam int IDX_W = $clog2(QUEUE_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = count_width(QUEUE_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QUEUE_DEPTH);

    logic [DATA_WIDTH-1:0] storage [QUEUE_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [IDX_W-1:0]      head_idx;
    logic [IDX_W-1:0]      tail_idx;
    logic [CNT_W-1:0]      used;
    logic [CNT_W-1:0]      free;
    logic [CNT_W-1:0]      enq_req;
    logic [CNT_W-1:0]      deq_req;
    logic [CNT_W-1:0]      enq_step;
    logic [CNT_W-1:0]      deq_step;
    logic                  enq_ready;
    logic                  enq_fire;

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];
    assign used     = CNT_W'(tail - head);
    assign free     = DEPTH_CNT - used;
    assign enq_req  = CNT_W'(q.enq_count_in);
    assign deq_req  = CNT_W'(q.deq_count_in);

    // Acceptance looks only at the start-of-cycle free count, so same-cycle
    // dequeues never feed the ready path.
    assign enq_ready = (enq_req <= free);
    assign enq_fire  = enq_ready && !q.flush_in;
    assign enq_step  = enq_fire ? enq_req : '0;
    assign deq_step  = (deq_req < used) ? deq_req : used;

    queue_ptr_ctr #(
        .PTR_W(PTR_W),
        .INC_W(CNT_W)
    ) u_head_ptr (
        .clk  (clk),
        .rst  (rst),
        .clear(q.flush_in),
        .inc  (deq_step),
        .ptr  (head)
    );

    queue_ptr_ctr #(
        .PTR_W(PTR_W),
        .INC_W(CNT_W)
    ) u_tail_ptr (
        .clk  (clk),
        .rst  (rst),
        .clear(q.flush_in),
        .inc  (enq_step),
        .ptr  (tail)
    );

    // Storage carries no reset; validity is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            for (int i = 0; i < ENQ_WIDTH; i++) begin
                if (CNT_W'(i) < enq_req) begin
                    storage[tail_idx + IDX_W'(i)] <= q.wdata_in[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        q.rdata_out  = '0;
        q.rvalid_out = '0;
        for (int j = 0; j < DEQ_WIDTH; j++) begin
            q.rdata_out[j*DATA_WIDTH +: DATA_WIDTH] = storage[head_idx + IDX_W'(j)];
            q.rvalid_out[j] = (used > CNT_W'(j));
        end
    end

    assign q.enq_ready_out  = enq_ready;
    assign q.used_count_out = used;
    assign q.free_count_out = free;
    assign q.full_out       = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);
    assign q.empty_out      = (head == tail);

endmodule

// File: tb/tb_multi_port_queue.sv
// Scoreboard bench for multi_port_queue: a queue-based model predicts each
// cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_multi_port_queue;
    import multi_port_queue_pkg::*;

    localparam int DW    = DEFAULT_DATA_WIDTH;
    localparam int DEPTH = DEFAULT_QUEUE_DEPTH;
    localparam int EW    = DEFAULT_ENQ_WIDTH;
    localparam int XW    = DEFAULT_DEQ_WIDTH;

    typedef struct {
        int          used;
        logic [1:0]  rvalid;
        logic [31:0] slot0;
        logic [31:0] slot1;
        bit          ready;
        bit          full;
        bit          empty;
    } expect_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] model_q [$];
    expect_t     exp_q [$];

    always #5 clk = ~clk;

    multi_port_queue_if #(
        .DATA_WIDTH(DW), .QUEUE_DEPTH(DEPTH), .ENQ_WIDTH(EW), .DEQ_WIDTH(XW)
    ) qif ();

    multi_port_queue #(
        .DATA_WIDTH(DW), .QUEUE_DEPTH(DEPTH), .ENQ_WIDTH(EW), .DEQ_WIDTH(XW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .q  (qif)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle of stimulus: predict outputs from the current model contents,
    // queue the prediction, then advance the model past the coming edge.
    task automatic applyStimulus(input bit flush, input int enq_n, input logic [31:0] w0,
                                 input logic [31:0] w1, input int deq_n);
        expect_t e;
        int      used;
        int      pops;
        @(posedge clk);
        #1;
        qif.flush_in     = flush;
        qif.enq_count_in = 2'(enq_n);
        qif.wdata_in     = {w1, w0};
        qif.deq_count_in = 2'(deq_n);
        used     = model_q.size();
        e.used   = used;
        e.rvalid = {used > 1, used > 0};
        e.slot0  = (used > 0) ? model_q[0] : 32'h0;
        e.slot1  = (used > 1) ? model_q[1] : 32'h0;
        e.ready  = (enq_n <= DEPTH - used);
        e.full   = (used == DEPTH);
        e.empty  = (used == 0);
        exp_q.push_back(e);
        if (flush) begin
            model_q.delete();
        end else begin
            pops = (deq_n < used) ? deq_n : used;
            for (int i = 0; i < pops; i++) void'(model_q.pop_front());
            if (e.ready) begin
                if (enq_n > 0) model_q.push_back(w0);
                if (enq_n > 1) model_q.push_back(w1);
            end
        end
    endtask

    task automatic checkEmptyNow(input string tag);
        checkOutput({tag, "_empty"}, 32'(qif.empty_out), 32'd1);
        checkOutput({tag, "_full"}, 32'(qif.full_out), 32'd0);
        checkOutput({tag, "_used"}, 32'(qif.used_count_out), 32'd0);
        checkOutput({tag, "_free"}, 32'(qif.free_count_out), 32'(DEPTH));
        checkOutput({tag, "_rvalid"}, 32'(qif.rvalid_out), 32'd0);
    endtask

    always @(negedge clk) begin
        expect_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("used", 32'(qif.used_count_out), 32'(e.used));
            checkOutput("free", 32'(qif.free_count_out), 32'(DEPTH - e.used));
            checkOutput("rvalid", 32'(qif.rvalid_out), 32'(e.rvalid));
            checkOutput("full", 32'(qif.full_out), 32'(e.full));
            checkOutput("empty", 32'(qif.empty_out), 32'(e.empty));
            checkOutput("enq_ready", 32'(qif.enq_ready_out), 32'(e.ready));
            if (e.rvalid[0]) checkOutput("rdata_slot0", qif.rdata_out[31:0], e.slot0);
            if (e.rvalid[1]) checkOutput("rdata_slot1", qif.rdata_out[63:32], e.slot1);
        end
    end

    initial begin
        rst              = 1'b1;
        qif.flush_in     = 1'b0;
        qif.enq_count_in = '0;
        qif.wdata_in     = '0;
        qif.deq_count_in = '0;
        #12;
        rst = 1'b0;
        #1;
        checkEmptyNow("reset");
        checkOutput("reset_enq_ready", 32'(qif.enq_ready_out), 32'd1);

        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 2, 32'hcafebabe, 32'hecebcafe, 0);
        applyStimulus(0, 1, 32'hbabebeef, 32'h0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 2);
        applyStimulus(0, 0, 0, 0, 2);
        applyStimulus(0, 0, 0, 0, 0);

        // Fill to 63, bounce off the last free slot, then top up to full.
        for (int i = 0; i < 31; i++) applyStimulus(0, 2, 32'h1000 + 2 * i, 32'h1001 + 2 * i, 0);
        applyStimulus(0, 1, 32'h2000, 32'h0, 0);
        applyStimulus(0, 2, 32'h3000, 32'h3001, 0);
        applyStimulus(0, 1, 32'h3000, 32'h0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 2, 32'h4000, 32'h4001, 2);
        applyStimulus(0, 2, 32'h4000, 32'h4001, 0);
        for (int i = 0; i < 33; i++) applyStimulus(0, 0, 0, 0, 2);

        applyStimulus(0, 2, 32'h5000, 32'h5001, 0);
        applyStimulus(0, 2, 32'h5002, 32'h5003, 0);
        applyStimulus(0, 1, 32'h5004, 32'h0, 0);
        applyStimulus(1, 2, 32'h5005, 32'h5006, 1);
        applyStimulus(0, 0, 0, 0, 0);

        // Randomised phases alternate between filling and draining bias.
        for (int i = 0; i < 1500; i++) begin
            int enq_n;
            int deq_n;
            bit fill_phase;
            fill_phase = ((i / 120) % 2) == 0;
            enq_n = $urandom_range(0, 2);
            deq_n = $urandom_range(0, 2);
            if (fill_phase && $urandom_range(0, 3) != 0) deq_n = 0;
            if (!fill_phase && $urandom_range(0, 3) != 0) enq_n = 0;
            applyStimulus($urandom_range(0, 149) == 0, enq_n, $urandom, $urandom, deq_n);
        end

        for (int i = 0; i < 6; i++) applyStimulus(0, 2, $urandom, $urandom, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkEmptyNow("async_reset");
        qif.enq_count_in = '0;
        qif.deq_count_in = '0;
        qif.flush_in     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_q.delete();

        for (int i = 0; i < 200; i++) begin
            applyStimulus(0, $urandom_range(0, 2), $urandom, $urandom, $urandom_range(0, 2));
        end
        applyStimulus(0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
